idu_decoder: RTL and testbench
==============================

Name: idu_decoder

Overview:
- RV32I instruction-decode stage that produces the 4-bit ALU operation code and the operand/control bundle consumed by the execute stage.
- Accepts one instruction per cycle from fetch over a valid/ready handshake.
- Decodes it combinationally and holds the result in a one-entry output pipeline register, with valid/ready toward execute.
- Supports a flush input for redirects.

Parameters:
WIDTH, 32, datapath width of pc/imm (RV32 fixed; parameter kept for ALU symmetry)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage can accept
in_inst  in  32  raw instruction
in_pc  in  WIDTH  instruction address
flush  in  1  discard held and incoming instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  WIDTH  registered pc
out_alu_op  out  4  ALU operation code
out_src1_sel  out  2  0=rs1, 1=pc, 2=zero
out_src2_sel  out  2  0=rs2, 1=imm, 2=constant 4
out_imm  out  WIDTH  sign-extended immediate
out_rs1/out_rs2/out_rd  out  5 each  register indices
out_rf_wen  out  1  register write enable (forced 0 when rd==0)
out_mem_ren/out_mem_wen  out  1 each  load/store
out_mem_size  out  3  funct3 of load/store
out_branch  out  1  conditional branch; out_mem_size carries funct3
out_jal/out_jalr  out  1 each  jumps
out_ecall/out_ebreak  out  1 each  system
out_illegal  out  1  undecodable instruction

Behaviour:
- Handshake and flush:
  - Transfer in when in_valid & in_ready.
  - in_ready = ~out_valid | out_ready, which gives full throughput.
  - Transfer out when out_valid & out_ready.
  - On the clock edge with accept: the register loads the decoded bundle and out_valid becomes 1.
  - On the clock edge with drain only: out_valid becomes 0.
  - flush has priority: out_valid becomes 0 and the same-cycle input is dropped. in_ready stays per the formula.
- Reset:
  - out_valid=0; all bundle outputs 0.
  - out_alu_op=4'b0000.
  - rst mid-stream discards the held bundle.
- Stability: while out_valid & ~out_ready, all out_* are held constant.
- Latency: 1 cycle from accept to out_valid.
- ALU encoding (fixed):
  - add 0000, sub 0001, sll 0010, slt 0100, sltu 0110.
  - xor 1000, srl 1010, sra 1011, or 1100, and 1110.
  - pass-src2 1111.
- Per opcode:
  - LUI: 1111, src2=imm(U).
  - AUIPC: add, src1=pc, src2=imm(U).
  - JAL/JALR: add, src1=pc, src2=4, rf_wen; imm=J/I.
  - BRANCH: BEQ/BNE → sub; BLT/BGE → slt; BLTU/BGEU → sltu. src1=rs1, src2=rs2, imm=B, no rf_wen.
  - LOAD: add rs1+imm(I), mem_ren, rf_wen.
  - STORE: add rs1+imm(S), mem_wen.
  - OP-IMM: funct3 map; funct3=101 with inst[30] selects sra.
  - OP: funct3 map; inst[30] selects sub (f3=000) or sra (f3=101).
  - FENCE: add, no side effects.
  - SYSTEM: 0x00000073 → ecall; 0x00100073 → ebreak.
- Illegal (out_illegal=1; rf_wen, mem_*, branch, jal, jalr, ecall, ebreak all forced 0):
  - Unknown opcode.
  - inst[1:0]≠11.
  - OP funct7 not 0000000/0100000, or 0100000 with f3 ∉ {000,101}.
  - Shift-imm with inst[25]=1, or slli with inst[30]=1.
  - Branch f3 010/011.
  - Load f3 011/110/111.
  - Store f3 ≥ 011.
  - Other SYSTEM encodings.
  - Illegal instructions still flow through the handshake.

Decomposition:
- Shared package `npc_pkg`:
  - ALU op constants.
  - Opcode constants.
  - src1/src2 select enums.
- Sub-module `imm_gen`: combinational I/S/B/U/J immediate extraction, selected by opcode.
- `idu_decoder` holds the decode logic plus the output register and handshake.

Test Plan:
1. 0x002081B3 (add x3,x1,x2) then 0x402081B3 (sub) back-to-back, out_ready=1 → out_alu_op 0000 then 0001, rd=3, rs1=1, rs2=2, rf_wen=1, one per cycle, in_ready constant 1.
2. 0x40335293 (srai x5,x6,3) → alu_op 1011, src2_sel=1, imm=3, rd=5; 0x123450B7 (lui x1) → alu_op 1111, imm=0x12345000.
3. 0x0020C463 (blt x1,x2,+8) → alu_op 0100, branch=1, mem_size=100, imm=8, rf_wen=0; JAL rd=0 → rf_wen=0, src2_sel=2.
4. Backpressure: out_ready=0 for 3 cycles while in_valid=1 → out_* frozen, in_ready=0, next instruction accepted exactly in the cycle out_ready=1.
5. Flush coincident with in_valid and a held bundle → next cycle out_valid=0, flushed instruction never appears; rst during stall → out_valid=0, outputs 0.
6. 0x00000000 and 0x02000033-style bad funct7 (0x0600_0033) → out_illegal=1, all enables 0; 0x00000073 → ecall=1.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared decode constants: ALU operation codes, RV32I opcodes, operand selects
// and the registered decode bundle layout.
package npc_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_OR   = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b1110;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {SRC1_RS1 = 2'd0, SRC1_PC = 2'd1, SRC1_ZERO = 2'd2} src1_sel_e;
  typedef enum logic [1:0] {SRC2_RS2 = 2'd0, SRC2_IMM = 2'd1, SRC2_FOUR = 2'd2} src2_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_op;
    src1_sel_e       src1_sel;
    src2_sel_e       src2_sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rf_wen;
    logic            mem_ren;
    logic            mem_wen;
    logic [2:0]      mem_size;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            ecall;
    logic            ebreak;
    logic            illegal;
  } dec_bundle_t;

  // Shared OP/OP-IMM funct3 map; alt (inst[30]) only matters for shift-right.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/idu_decoder_imm_gen.sv
// Immediate extraction for RV32I; format chosen from the opcode. Shift-immediates
// yield the zero-extended shift amount rather than the raw I field.
module imm_gen
  import npc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      inst,
  output logic [WIDTH-1:0] imm
);

  logic [6:0] opc_s;
  logic [2:0] f3_s;

  assign opc_s = inst[6:0];
  assign f3_s  = inst[14:12];

  // Format select by opcode.
  always_comb begin
    imm = '0;
    case (opc_s)
      OPC_OP_IMM: begin
        if (f3_s == 3'b001 || f3_s == 3'b101) begin
          imm = {27'd0, inst[24:20]};
        end else begin
          imm = {{20{inst[31]}}, inst[31:20]};
        end
      end
      OPC_LOAD, OPC_JALR: imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm = {inst[31:12], 12'd0};
      OPC_JAL:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:    imm = '0;
    endcase
  end

endmodule

// File: rtl/idu_decoder.sv
// RV32I decode stage: combinational decode into a one-entry output register with
// valid/ready on both sides and a flush that discards held and incoming work.
module idu_decoder
  import npc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [3:0]       out_alu_op,
  output logic [1:0]       out_src1_sel,
  output logic [1:0]       out_src2_sel,
  output logic [WIDTH-1:0] out_imm,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_rf_wen,
  output logic             out_mem_ren,
  output logic             out_mem_wen,
  output logic [2:0]       out_mem_size,
  output logic             out_branch,
  output logic             out_jal,
  output logic             out_jalr,
  output logic             out_ecall,
  output logic             out_ebreak,
  output logic             out_illegal
);

  logic [WIDTH-1:0] imm_s;
  logic [6:0]       opc_s;
  logic [2:0]       f3_s;
  logic [6:0]       f7_s;
  logic             accept_s;
  logic             valid_r;
  dec_bundle_t      dec_s;
  dec_bundle_t      bundle_r;

  imm_gen #(.WIDTH(WIDTH)) u_imm_gen (.inst(in_inst), .imm(imm_s));

  assign opc_s    = in_inst[6:0];
  assign f3_s     = in_inst[14:12];
  assign f7_s     = in_inst[31:25];
  assign in_ready = ~valid_r | out_ready;
  assign accept_s = in_valid & in_ready;

  // Instruction decode into the execute bundle.
  always_comb begin
    dec_s         = '0;
    dec_s.pc      = in_pc;
    dec_s.imm     = imm_s;
    dec_s.rs1     = in_inst[19:15];
    dec_s.rs2     = in_inst[24:20];
    dec_s.rd      = in_inst[11:7];
    dec_s.alu_op  = ALU_ADD;
    dec_s.src1_sel = SRC1_RS1;
    dec_s.src2_sel = SRC2_RS2;
    if (in_inst[1:0] != 2'b11) begin
      dec_s.illegal = 1'b1;
    end else begin
      case (opc_s)
        OPC_LUI: begin
          dec_s.alu_op = ALU_PASS; dec_s.src1_sel = SRC1_ZERO;
          dec_s.src2_sel = SRC2_IMM; dec_s.rf_wen = 1'b1;
        end
        OPC_AUIPC: begin
          dec_s.src1_sel = SRC1_PC; dec_s.src2_sel = SRC2_IMM; dec_s.rf_wen = 1'b1;
        end
        OPC_JAL, OPC_JALR: begin
          dec_s.src1_sel = SRC1_PC; dec_s.src2_sel = SRC2_FOUR; dec_s.rf_wen = 1'b1;
          dec_s.jal  = (opc_s == OPC_JAL);
          dec_s.jalr = (opc_s == OPC_JALR);
        end
        OPC_BRANCH: begin
          dec_s.branch = 1'b1; dec_s.mem_size = f3_s;
          case (f3_s[2:1])
            2'b00:   dec_s.alu_op = ALU_SUB;
            2'b10:   dec_s.alu_op = ALU_SLT;
            2'b11:   dec_s.alu_op = ALU_SLTU;
            default: dec_s.illegal = 1'b1;
          endcase
        end
        OPC_LOAD: begin
          dec_s.src2_sel = SRC2_IMM; dec_s.mem_ren = 1'b1; dec_s.rf_wen = 1'b1;
          dec_s.mem_size = f3_s;
          dec_s.illegal  = (f3_s == 3'b011) || (f3_s[2:1] == 2'b11);
        end
        OPC_STORE: begin
          dec_s.src2_sel = SRC2_IMM; dec_s.mem_wen = 1'b1; dec_s.mem_size = f3_s;
          dec_s.illegal  = (f3_s >= 3'b011);
        end
        OPC_OP_IMM: begin
          dec_s.src2_sel = SRC2_IMM; dec_s.rf_wen = 1'b1;
          dec_s.alu_op   = alu_from_f3(f3_s, (f3_s == 3'b101) & in_inst[30]);
          if (f3_s == 3'b001) begin
            dec_s.illegal = in_inst[25] | in_inst[30];
          end else if (f3_s == 3'b101) begin
            dec_s.illegal = in_inst[25];
          end else begin
            dec_s.illegal = 1'b0;
          end
        end
        OPC_OP: begin
          dec_s.rf_wen = 1'b1;
          if (f7_s == 7'b0000000) begin
            dec_s.alu_op = alu_from_f3(f3_s, 1'b0);
          end else if (f7_s == 7'b0100000 && f3_s == 3'b000) begin
            dec_s.alu_op = ALU_SUB;
          end else if (f7_s == 7'b0100000 && f3_s == 3'b101) begin
            dec_s.alu_op = ALU_SRA;
          end else begin
            dec_s.illegal = 1'b1;
          end
        end
        OPC_FENCE: dec_s.alu_op = ALU_ADD;
        OPC_SYSTEM: begin
          if (in_inst == 32'h0000_0073) begin
            dec_s.ecall = 1'b1;
          end else if (in_inst == 32'h0010_0073) begin
            dec_s.ebreak = 1'b1;
          end else begin
            dec_s.illegal = 1'b1;
          end
        end
        default: dec_s.illegal = 1'b1;
      endcase
    end
    // Illegal instructions travel downstream but must have no side effects.
    if (dec_s.illegal) begin
      dec_s.rf_wen  = 1'b0; dec_s.mem_ren = 1'b0; dec_s.mem_wen = 1'b0;
      dec_s.branch  = 1'b0; dec_s.jal     = 1'b0; dec_s.jalr    = 1'b0;
      dec_s.ecall   = 1'b0; dec_s.ebreak  = 1'b0;
    end else begin
      dec_s.rf_wen = dec_s.rf_wen & (dec_s.rd != 5'd0);
    end
  end

  // Output pipeline register; flush outranks accept, and a stall holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r  <= 1'b0;
      bundle_r <= '0;
    end else if (flush) begin
      valid_r  <= 1'b0;
    end else if (accept_s) begin
      valid_r  <= 1'b1;
      bundle_r <= dec_s;
    end else if (out_ready) begin
      valid_r  <= 1'b0;
    end else begin
      valid_r  <= valid_r;
    end
  end

  assign out_valid    = valid_r;
  assign out_pc       = bundle_r.pc;
  assign out_alu_op   = bundle_r.alu_op;
  assign out_src1_sel = bundle_r.src1_sel;
  assign out_src2_sel = bundle_r.src2_sel;
  assign out_imm      = bundle_r.imm;
  assign out_rs1      = bundle_r.rs1;
  assign out_rs2      = bundle_r.rs2;
  assign out_rd       = bundle_r.rd;
  assign out_rf_wen   = bundle_r.rf_wen;
  assign out_mem_ren  = bundle_r.mem_ren;
  assign out_mem_wen  = bundle_r.mem_wen;
  assign out_mem_size = bundle_r.mem_size;
  assign out_branch   = bundle_r.branch;
  assign out_jal      = bundle_r.jal;
  assign out_jalr     = bundle_r.jalr;
  assign out_ecall    = bundle_r.ecall;
  assign out_ebreak   = bundle_r.ebreak;
  assign out_illegal  = bundle_r.illegal;

endmodule

// File: tb/tb_idu_decoder.sv
// Directed-vector bench for idu_decoder with hand-computed expectations.
module tb_idu_decoder;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [3:0]  out_alu_op;
  logic [1:0]  out_src1_sel, out_src2_sel;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rf_wen, out_mem_ren, out_mem_wen, out_branch;
  logic        out_jal, out_jalr, out_ecall, out_ebreak, out_illegal;
  logic [2:0]  out_mem_size;
  logic [7:0]  en_s;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  idu_decoder #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_alu_op(out_alu_op),
    .out_src1_sel(out_src1_sel), .out_src2_sel(out_src2_sel), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rf_wen(out_rf_wen),
    .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen), .out_mem_size(out_mem_size),
    .out_branch(out_branch), .out_jal(out_jal), .out_jalr(out_jalr),
    .out_ecall(out_ecall), .out_ebreak(out_ebreak), .out_illegal(out_illegal)
  );

  // {rf_wen, mem_ren, mem_wen, branch, jal, jalr, ecall, ebreak}
  assign en_s = {out_rf_wen, out_mem_ren, out_mem_wen, out_branch,
                 out_jal, out_jalr, out_ecall, out_ebreak};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
    flush = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu", {28'd0, out_alu_op}, 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_en", {24'd0, en_s}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // add then sub back-to-back
    issue(32'h0020_81B3, 32'h100);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_alu", {28'd0, out_alu_op}, 32'h0);
    chk("add_regs", {17'd0, out_rd, out_rs1, out_rs2}, {17'd0, 5'd3, 5'd1, 5'd2});
    chk("add_en", {24'd0, en_s}, 32'h80);
    chk("add_pc", out_pc, 32'h100);
    chk("add_in_ready", {31'd0, in_ready}, 32'd1);
    issue(32'h4020_81B3, 32'h104);
    chk("sub_alu", {28'd0, out_alu_op}, 32'h1);
    chk("sub_pc", out_pc, 32'h104);
    chk("sub_valid", {31'd0, out_valid}, 32'd1);

    // srai and lui
    issue(32'h4033_5293, 32'h108);
    chk("srai_alu", {28'd0, out_alu_op}, 32'hB);
    chk("srai_src2", {30'd0, out_src2_sel}, 32'd1);
    chk("srai_imm", out_imm, 32'd3);
    chk("srai_rd_rs1", {22'd0, out_rd, out_rs1}, {22'd0, 5'd5, 5'd6});
    issue(32'h1234_50B7, 32'h10C);
    chk("lui_alu", {28'd0, out_alu_op}, 32'hF);
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_en", {24'd0, en_s}, 32'h80);

    // branch, jumps, load, store
    issue(32'h0020_C463, 32'h110);
    chk("blt_alu", {28'd0, out_alu_op}, 32'h4);
    chk("blt_size", {29'd0, out_mem_size}, 32'd4);
    chk("blt_imm", out_imm, 32'd8);
    chk("blt_en", {24'd0, en_s}, 32'h10);
    issue(32'h0080_006F, 32'h114);
    chk("jal_en", {24'd0, en_s}, 32'h08);
    chk("jal_sel", {28'd0, out_src1_sel, out_src2_sel}, {28'd0, 2'd1, 2'd2});
    chk("jal_imm", out_imm, 32'd8);
    issue(32'h0000_80E7, 32'h118);
    chk("jalr_en", {24'd0, en_s}, 32'h84);
    issue(32'h0041_2283, 32'h11C);
    chk("lw_en", {24'd0, en_s}, 32'hC0);
    chk("lw_imm_size", {out_imm[28:0], out_mem_size}, {29'd4, 3'd2});
    issue(32'hFE51_2E23, 32'h120);
    chk("sw_en", {24'd0, en_s}, 32'h20);
    chk("sw_imm", out_imm, 32'hFFFF_FFFC);

    // backpressure: hold A while B waits
    issue(32'h0020_81B3, 32'h200);
    out_ready = 1'b0; in_inst = 32'h4020_81B3; in_pc = 32'h204;
    #1;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", {out_pc[27:0], out_alu_op}, {28'h200, 4'h0});
      chk("bp_valid_rdy", {30'd0, out_valid, in_ready}, 32'd2);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_next", {out_pc[27:0], out_alu_op}, {28'h204, 4'h1});

    // flush with held bundle and incoming instruction
    flush = 1'b1;
    issue(32'h4033_5293, 32'h300);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("flush_dropped", {31'd0, out_valid}, 32'd0);

    // reset during stall
    issue(32'h1234_50B7, 32'h400);
    out_ready = 1'b0; in_valid = 1'b0;
    step();
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_pc_imm", out_pc | out_imm, 32'd0);
    chk("rst2_fields", {13'd0, out_alu_op, out_rd, en_s, out_illegal}, 32'd0);

    // illegal and system
    issue(32'h0000_0000, 32'h500);
    chk("zero_ill", {23'd0, out_illegal, en_s}, 32'h100);
    issue(32'h0600_0033, 32'h504);
    chk("f7_ill", {23'd0, out_illegal, en_s}, 32'h100);
    chk("f7_valid", {31'd0, out_valid}, 32'd1);
    issue(32'h4030_9293, 32'h508);
    chk("slli30_ill", {23'd0, out_illegal, en_s}, 32'h100);
    issue(32'h0000_B283, 32'h50C);
    chk("ld_ill", {23'd0, out_illegal, en_s}, 32'h100);
    issue(32'h0000_0073, 32'h510);
    chk("ecall", {23'd0, out_illegal, en_s}, 32'h002);
    issue(32'h0010_0073, 32'h514);
    chk("ebreak", {23'd0, out_illegal, en_s}, 32'h001);
    in_valid = 1'b0;
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
